// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: lets NREQ clients share one external 16-bit adder.
// Requests are picked round-robin, the winning operands are registered into
// the adder, and the sum plus flags are held in a response register until the
// consumer takes them.
module adder_share_ctrl #(
  parameter  int NREQ = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_x,
  input  logic [16*NREQ-1:0]   req_y,
  output logic [NREQ-1:0]      req_ready,
  output logic [15:0]          alu_x,
  output logic [15:0]          alu_y,
  input  logic [15:0]          alu_z,
  input  logic                 alu_zero,
  input  logic                 alu_sign,
  input  logic                 alu_carry,
  input  logic                 alu_parity,
  input  logic                 alu_overflow,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IW-1:0]        resp_id,
  output logic [15:0]          resp_z,
  output logic [4:0]           resp_flags,
  output logic [15:0]          ops_done
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] cur_id;
  logic [IW-1:0] grant_id;
  logic          grant_any;
  logic [IW:0]   cand;
  logic [15:0]   sel_x;
  logic [15:0]   sel_y;

  // Round-robin search: first pending request at or after rr_ptr, wrapping at NREQ.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (!grant_any && req_valid[cand[IW-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = cand[IW-1:0];
      end
    end
  end

  // Operand mux selecting the granted requester's X and Y slices.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_id == IW'(k)) begin
        sel_x = req_x[16*k +: 16];
        sel_y = req_y[16*k +: 16];
      end
    end
  end

  // Grant pulse is only offered while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (!rst && (state == IDLE) && grant_any) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // Next-state logic: one cycle in EXEC, then wait in RESP for the consumer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: capture operands on grant, capture adder result in EXEC, count handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      cur_id     <= '0;
      alu_x      <= '0;
      alu_y      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_z     <= '0;
      resp_flags <= '0;
      ops_done   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            alu_x  <= sel_x;
            alu_y  <= sel_y;
            cur_id <= grant_id;
          end
        end
        EXEC: begin
          resp_z     <= alu_z;
          resp_flags <= {alu_overflow, alu_parity, alu_carry, alu_sign, alu_zero};
          resp_id    <= cur_id;
          resp_valid <= 1'b1;
          rr_ptr     <= (cur_id == IW'(NREQ - 1)) ? '0 : cur_id + IW'(1);
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            ops_done   <= ops_done + 16'd1;
          end
        end
        default: begin
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb_adder_share_ctrl: drives the shared-adder controller with directed
// requests, supplies the external adder, and compares every cycle against a
// transaction-level reference plus hand-computed literal results.
module tb_adder_share_ctrl;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] op_x [4];
  logic [15:0] op_y [4];
  logic [63:0] req_x;
  logic [63:0] req_y;
  logic [3:0]  req_ready;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [15:0] alu_z;
  logic        alu_zero;
  logic        alu_sign;
  logic        alu_carry;
  logic        alu_parity;
  logic        alu_overflow;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_id;
  logic [15:0] resp_z;
  logic [4:0]  resp_flags;
  logic [15:0] ops_done;
  logic [16:0] alu_sum;

  int errors = 0;
  int checks = 0;

  // Reference state: one outstanding transaction at most.
  bit          model_live = 1'b0;
  bit          mdl_busy;
  bit          mdl_has_resp;
  logic [1:0]  mdl_ptr;
  logic [1:0]  mdl_id;
  logic [15:0] mdl_x;
  logic [15:0] mdl_y;
  logic [15:0] mdl_z;
  logic [4:0]  mdl_flags;
  logic [1:0]  mdl_resp_id;
  logic [15:0] mdl_ops;

  assign req_x = {op_x[3], op_x[2], op_x[1], op_x[0]};
  assign req_y = {op_y[3], op_y[2], op_y[1], op_y[0]};

  // The single external adder the controller time-shares.
  assign alu_sum      = {1'b0, alu_x} + {1'b0, alu_y};
  assign alu_z        = alu_sum[15:0];
  assign alu_carry    = alu_sum[16];
  assign alu_zero     = (alu_z == 16'h0000);
  assign alu_sign     = alu_z[15];
  assign alu_parity   = ~^alu_z;
  assign alu_overflow = (alu_x[15] == alu_y[15]) && (alu_z[15] != alu_x[15]);

  adder_share_ctrl #(.NREQ(NREQ)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_ready    (req_ready),
    .alu_x        (alu_x),
    .alu_y        (alu_y),
    .alu_z        (alu_z),
    .alu_zero     (alu_zero),
    .alu_sign     (alu_sign),
    .alu_carry    (alu_carry),
    .alu_parity   (alu_parity),
    .alu_overflow (alu_overflow),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_z       (resp_z),
    .resp_flags   (resp_flags),
    .ops_done     (ops_done)
  );

  always #5 clk = ~clk;

  // Round-robin pick: first valid index scanning from ptr, or -1 when none.
  function automatic int pick_grant(logic [3:0] valid, logic [1:0] ptr);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (int'(ptr) + k) % 4;
      if (valid[idx]) return idx;
    end
    return -1;
  endfunction

  // Arithmetic reference for sum and flags {overflow, parity, carry, sign, zero}.
  function automatic logic [20:0] add_model(logic [15:0] x, logic [15:0] y);
    int          usum;
    int          ssum;
    logic [15:0] z;
    logic [4:0]  f;
    usum = int'(x) + int'(y);
    ssum = int'($signed(x)) + int'($signed(y));
    z    = 16'(usum);
    f[0] = (z == 16'h0000);
    f[1] = z[15];
    f[2] = (usum > 65535);
    f[3] = (($countones(z) % 2) == 0);
    f[4] = (ssum > 32767) || (ssum < -32768);
    return {f, z};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [15:0] x, input logic [15:0] y);
    op_x[id]      = x;
    op_y[id]      = y;
    req_valid[id] = 1'b1;
  endtask

  // Reference update on each rising edge from the inputs present before it.
  always @(posedge clk) begin
    if (rst) begin
      model_live   = 1'b1;
      mdl_busy     = 1'b0;
      mdl_has_resp = 1'b0;
      mdl_ptr      = '0;
      mdl_id       = '0;
      mdl_x        = '0;
      mdl_y        = '0;
      mdl_z        = '0;
      mdl_flags    = '0;
      mdl_resp_id  = '0;
      mdl_ops      = '0;
    end else if (model_live) begin
      if (!mdl_busy) begin
        int g;
        g = pick_grant(req_valid, mdl_ptr);
        if (g >= 0) begin
          mdl_busy = 1'b1;
          mdl_id   = 2'(g);
          mdl_x    = op_x[g];
          mdl_y    = op_y[g];
        end
      end else if (!mdl_has_resp) begin
        {mdl_flags, mdl_z} = add_model(mdl_x, mdl_y);
        mdl_resp_id  = mdl_id;
        mdl_has_resp = 1'b1;
        mdl_ptr      = 2'((int'(mdl_id) + 1) % 4);
      end else if (resp_ready) begin
        mdl_has_resp = 1'b0;
        mdl_busy     = 1'b0;
        mdl_ops      = mdl_ops + 16'd1;
      end
    end
  end

  // Per-cycle comparison against the reference, sampled on the falling edge.
  always @(negedge clk) begin
    if (model_live) begin
      int         g;
      logic [3:0] exp_ready;
      g         = pick_grant(req_valid, mdl_ptr);
      exp_ready = '0;
      if (!rst && !mdl_busy && (g >= 0)) exp_ready[g] = 1'b1;
      checkOutput("cmp req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("cmp resp_valid", 32'(resp_valid), 32'(mdl_has_resp));
      checkOutput("cmp ops_done", 32'(ops_done), 32'(mdl_ops));
      checkOutput("cmp alu_x", 32'(alu_x), 32'(mdl_x));
      checkOutput("cmp alu_y", 32'(alu_y), 32'(mdl_y));
      checkOutput("cmp resp_z", 32'(resp_z), 32'(mdl_z));
      checkOutput("cmp resp_flags", 32'(resp_flags), 32'(mdl_flags));
      checkOutput("cmp resp_id", 32'(resp_id), 32'(mdl_resp_id));
    end
  end

  // One complete operation with resp_ready held high and literal expectations.
  task automatic doOp(input int id, input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] exp_z, input logic [4:0] exp_flags,
                      input logic [15:0] exp_ops);
    bit got;
    got = 1'b0;
    applyStimulus(id, x, y);
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
    end
    checkOutput("grant seen", 32'(got), 32'd1);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
    @(negedge clk);
    checkOutput("resp_valid at T+1", 32'(resp_valid), 32'd0);
    @(negedge clk);
    checkOutput("resp_valid at T+2", 32'(resp_valid), 32'd1);
    checkOutput("lit resp_z", 32'(resp_z), 32'(exp_z));
    checkOutput("lit resp_flags", 32'(resp_flags), 32'(exp_flags));
    checkOutput("lit resp_id", 32'(resp_id), 32'(id));
    @(negedge clk);
    checkOutput("lit ops_done", 32'(ops_done), 32'(exp_ops));
    checkOutput("resp_valid after handshake", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Hard time limit so the bench never hangs.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenario sequence.
  initial begin
    int         order [5];
    int         n;
    bit         got;
    logic [3:0] rr_valid_all;
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      op_x[i] = '0;
      op_y[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset ops_done", 32'(ops_done), 32'd0);
    checkOutput("reset alu_x", 32'(alu_x), 32'd0);
    checkOutput("reset resp_z", 32'(resp_z), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    resp_ready = 1'b1;

    $display("[TB] single request and flag corners");
    doOp(0, 16'h1234, 16'h1111, 16'h2345, 5'b01000, 16'd1);
    doOp(1, 16'h7FFF, 16'h0001, 16'h8000, 5'b10010, 16'd2);
    doOp(2, 16'hFFFF, 16'h0001, 16'h0000, 5'b01101, 16'd3);

    $display("[TB] round-robin with all requesters pending");
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      op_x[i] = 16'h1100 * 16'(i + 1);
      op_y[i] = 16'h0022 + 16'(i);
    end
    rr_valid_all = 4'hF;
    req_valid    = rr_valid_all;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          if (req_ready[k]) order[n] = k;
        end
        n++;
      end
    end
    checkOutput("rr grant count", 32'(n), 32'd5);
    @(posedge clk);
    #1 req_valid = '0;
    checkOutput("rr grant 0", 32'(order[0]), 32'd0);
    checkOutput("rr grant 1", 32'(order[1]), 32'd1);
    checkOutput("rr grant 2", 32'(order[2]), 32'd2);
    checkOutput("rr grant 3", 32'(order[3]), 32'd3);
    checkOutput("rr grant 4", 32'(order[4]), 32'd0);
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] backpressure on the response");
    resp_ready = 1'b0;
    applyStimulus(2, 16'h4000, 16'h4000);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready[2]) got = 1'b1;
    end
    checkOutput("bp grant seen", 32'(got), 32'd1);
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    applyStimulus(3, 16'h0003, 16'h0004);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp resp_valid held", 32'(resp_valid), 32'd1);
      checkOutput("bp req_ready idle", 32'(req_ready), 32'd0);
      checkOutput("bp resp_z held", 32'(resp_z), 32'h8000);
      checkOutput("bp resp_flags held", 32'(resp_flags), 32'h12);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp before handshake req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    checkOutput("bp next grant one cycle later", 32'(req_ready), 32'b1000);
    checkOutput("bp resp_valid cleared", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1 req_valid[3] = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] reset in the middle of an operation");
    applyStimulus(0, 16'h0F0F, 16'h00F0);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready[0]) got = 1'b1;
    end
    checkOutput("midrst grant seen", 32'(got), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midrst resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("midrst ops_done", 32'(ops_done), 32'd0);
    checkOutput("midrst req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    doOp(0, 16'h0F0F, 16'h00F0, 16'h0FFF, 5'b01000, 16'd1);

    $display("[TB] ops_done wrap");
    #1 force dut.ops_done = 16'hFFFE;
    mdl_ops = 16'hFFFE;
    #1 release dut.ops_done;
    doOp(1, 16'h0001, 16'h0001, 16'h0002, 5'b00000, 16'hFFFF);
    doOp(2, 16'h8000, 16'h8000, 16'h0000, 5'b11101, 16'h0000);

    repeat (2) @(posedge clk);
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
